// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, parity modes and baud divisor helpers for the UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PARITY_EVEN) ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: single-clock byte FIFO with push/pop/full/empty/count; push is accepted when full only alongside a pop.
module uart_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [W-1:0]           i_din,
    output logic [W-1:0]           o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_wr;
    logic          w_rd;

    assign w_wr    = i_push & (~o_full | i_pop);
    assign w_rd    = i_pop & ~o_empty;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_wr);
            r_rd_ptr <= r_rd_ptr + AW'(w_rd);
            r_count  <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffers bytes on rising edges of tx_ready and serialises them as async frames on txd.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int BW       = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    state_t                      r_state, w_state_n;
    logic [BW-1:0]               r_baud_cnt, w_baud_cnt_n;
    logic [2:0]                  r_bit_cnt, w_bit_cnt_n;
    logic [7:0]                  r_shift, w_shift_n;
    logic                        r_par, w_par_n;
    logic                        r_txd, w_txd_n;
    logic                        r_tx_ready_d;
    logic                        r_overflow;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_bit_end;
    logic                        w_full;
    logic                        w_empty;
    logic [7:0]                  w_dout;
    logic [$clog2(FIFO_DEPTH):0] w_count;

    assign w_push    = tx_ready & ~r_tx_ready_d;
    assign w_bit_end = r_baud_cnt == BAUD_LAST;
    assign txd       = r_txd;
    assign busy      = (r_state != S_IDLE) | (w_count != '0);
    assign fifo_full = w_full;
    assign overflow  = r_overflow;

    uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (tx_data),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_baud_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_txd        <= 1'b1;
            r_tx_ready_d <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_baud_cnt   <= w_baud_cnt_n;
            r_bit_cnt    <= w_bit_cnt_n;
            r_shift      <= w_shift_n;
            r_par        <= w_par_n;
            r_txd        <= w_txd_n;
            r_tx_ready_d <= tx_ready;
            r_overflow   <= r_overflow | (w_push & w_full & ~w_pop);
        end
    end

    // txd is registered from the next-state level so the line never glitches
    always_comb begin
        w_state_n    = r_state;
        w_baud_cnt_n = w_bit_end ? '0 : r_baud_cnt + BW'(1);
        w_bit_cnt_n  = r_bit_cnt;
        w_shift_n    = r_shift;
        w_par_n      = r_par;
        w_txd_n      = r_txd;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_cnt_n = '0;
                w_pop        = ~w_empty;
            end
            S_START: if (w_bit_end) begin
                w_state_n   = S_DATA;
                w_bit_cnt_n = '0;
                w_txd_n     = r_shift[0];
            end
            S_DATA: if (w_bit_end) begin
                w_shift_n   = r_shift >> 1;
                w_bit_cnt_n = r_bit_cnt + 3'd1;
                w_txd_n     = r_shift[1];
                if (r_bit_cnt == 3'd7) begin
                    w_bit_cnt_n = '0;
                    w_state_n   = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
                    w_txd_n     = (PARITY != PARITY_NONE) ? r_par : 1'b1;
                end
            end
            S_PARITY: if (w_bit_end) begin
                w_state_n = S_STOP;
                w_txd_n   = 1'b1;
            end
            S_STOP: if (w_bit_end) begin
                w_bit_cnt_n = r_bit_cnt + 3'd1;
                if (r_bit_cnt == STOP_LAST) begin
                    w_bit_cnt_n = '0;
                    w_state_n   = S_IDLE;
                    w_pop       = ~w_empty;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
        if (w_pop) begin
            w_state_n    = S_START;
            w_baud_cnt_n = '0;
            w_shift_n    = w_dout;
            w_par_n      = parity_bit(w_dout, PARITY);
            w_txd_n      = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three transmitter configurations driven in parallel and checked every cycle against a queue-based frame model.
module tb_uart_tx;

    localparam int BD    = 10;
    localparam int DEPTH = 4;
    localparam int PAR [3] = '{0, 2, 1};
    localparam int STP [3] = '{1, 2, 1};

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       tx_ready = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic [2:0] txd, busy, fifo_full, overflow;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    logic [7:0] m_q [3][$];
    bit         m_act [3];
    int         m_t [3];
    logic [7:0] m_cur [3];
    bit         m_ovf [3];
    bit         m_prev;

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u0 (
        .clk(clk), .rst(rst), .tx_ready(tx_ready), .tx_data(tx_data),
        .txd(txd[0]), .busy(busy[0]), .fifo_full(fifo_full[0]), .overflow(overflow[0]));
    uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u1 (
        .clk(clk), .rst(rst), .tx_ready(tx_ready), .tx_data(tx_data),
        .txd(txd[1]), .busy(busy[1]), .fifo_full(fifo_full[1]), .overflow(overflow[1]));
    uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u2 (
        .clk(clk), .rst(rst), .tx_ready(tx_ready), .tx_data(tx_data),
        .txd(txd[2]), .busy(busy[2]), .fifo_full(fifo_full[2]), .overflow(overflow[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int flen(input int par, input int stp);
        return BD * (9 + (par != 0 ? 1 : 0) + stp);
    endfunction

    // Line level t clocks into a frame: start, 8 data bits LSB first, optional parity, stop bits.
    function automatic bit lvl(input logic [7:0] b, input int t, input int par);
        int i;
        i = t / BD;
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == 9 && par == 2) return ($countones(b) % 2) == 1;
        if (i == 9 && par == 1) return ($countones(b) % 2) == 0;
        return 1'b1;
    endfunction

    task automatic model_step();
        bit push;
        bit pp;
        int sz;
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_q[k].delete();
                m_act[k] = 1'b0;
                m_t[k]   = 0;
                m_ovf[k] = 1'b0;
            end
            m_prev = 1'b0;
        end else begin
            push = tx_ready && !m_prev;
            for (int k = 0; k < 3; k++) begin
                sz = m_q[k].size();
                pp = sz > 0 && (!m_act[k] || m_t[k] == flen(PAR[k], STP[k]) - 1);
                if (pp) begin
                    m_cur[k] = m_q[k].pop_front();
                    m_act[k] = 1'b1;
                    m_t[k]   = 0;
                end else if (m_act[k]) begin
                    if (m_t[k] == flen(PAR[k], STP[k]) - 1) m_act[k] = 1'b0;
                    else m_t[k]++;
                end
                if (push) begin
                    if (sz < DEPTH || pp) m_q[k].push_back(tx_data);
                    else m_ovf[k] = 1'b1;
                end
            end
            m_prev = tx_ready;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("txd%0d", k), 32'(txd[k]), 32'(m_act[k] ? lvl(m_cur[k], m_t[k], PAR[k]) : 1'b1));
                chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(m_act[k] || m_q[k].size() != 0));
                chk($sformatf("full%0d", k), 32'(fifo_full[k]), 32'(m_q[k].size() == DEPTH));
                chk($sformatf("ovf%0d", k), 32'(overflow[k]), 32'(m_ovf[k]));
            end
        end
    end

    task automatic pulse(input logic [7:0] d, input int hi, input int lo);
        @(negedge clk);
        tx_data  = d;
        tx_ready = 1'b1;
        repeat (hi) @(negedge clk);
        tx_ready = 1'b0;
        repeat (lo - 1) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 3'b000 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] seq4 [4] = '{8'h00, 8'h0B, 8'h00, 8'h05};
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("rst_txd", 32'(txd), 32'h7);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_full", 32'(fifo_full), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);

        pulse(8'h73, 1, 1);
        wait_idle();
        pulse(8'h73, 1000, 1);
        wait_idle();

        for (int i = 0; i < 4; i++) pulse(seq4[i], 1, 1);
        wait_idle();

        for (int i = 1; i <= 6; i++) pulse(8'(i), 1, 1);
        chk("burst_full", 32'(fifo_full), 32'h7);
        chk("burst_ovf", 32'(overflow), 32'h7);
        wait_idle();
        chk("ovf_sticky", 32'(overflow), 32'h7);

        do_reset();
        chk("ovf_clear", 32'(overflow), 32'h0);
        pulse(8'h0A, 1, 1);
        pulse(8'h0A, 1, 1);
        wait_idle();

        pulse(8'h55, 1, 1);
        repeat (40) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("midrst_txd", 32'(txd), 32'h7);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'h0);

        repeat (60) pulse(8'($urandom), $urandom_range(1, 4), $urandom_range(1, 160));
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
